// File: rtl/pool_layer_1_pkg.sv
// Shared constants for layer 1: q8.24 scale, feature-map geometry and pool FSM states.
package pool_layer_1_pkg;

  localparam logic [31:0] Q824_ONE     = 32'h0100_0000;
  localparam int          L1_FMAP_SIZE = 24;
  localparam int          L1_CHANNELS  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pool_layer_1_channel.sv
// One channel of the 2x2/stride-2 max pool.
// The horizontal pair max of each even row is parked in a half-row line buffer.
// On the odd row it is combined with the current pair to produce the window max.
module pool_channel
  import pool_layer_1_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int IN_WIDTH  = L1_FMAP_SIZE,
  parameter int COL_BITS  = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [COL_BITS-1:0]  i_col,
  input  logic                 i_row_odd,
  input  logic [DATA_BITS-1:0] i_data,
  output logic [DATA_BITS-1:0] o_data
);

  localparam int HALF = IN_WIDTH / 2;

  logic [DATA_BITS-1:0] r_pair;
  logic [DATA_BITS-1:0] r_lbuf [HALF];
  logic [DATA_BITS-1:0] r_out;

  logic [COL_BITS-2:0]  w_idx;
  logic [DATA_BITS-1:0] w_lbuf_sel;
  logic [DATA_BITS-1:0] w_pair_max;
  logic [DATA_BITS-1:0] w_win_max;

  // Compare tree: unsigned, samples are non-negative q8.24.
  always_comb begin
    w_idx      = i_col[COL_BITS-1:1];
    w_lbuf_sel = r_lbuf[w_idx];
    w_pair_max = (r_pair > i_data) ? r_pair : i_data;
    w_win_max  = (w_lbuf_sel > w_pair_max) ? w_lbuf_sel : w_pair_max;
  end

  // Pair capture, line-buffer fill on even rows, result register on odd rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair <= '0;
      r_out  <= '0;
      for (int i = 0; i < HALF; i++) begin
        r_lbuf[i] <= '0;
      end
    end else if (i_valid) begin
      if (!i_col[0]) begin
        r_pair <= i_data;
      end else if (!i_row_odd) begin
        r_lbuf[w_idx] <= w_pair_max;
      end else begin
        r_out <= w_win_max;
      end
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/pool_layer_1.sv
// Layer-1 max-pool stage: six channels of 24x24 q8.24 reduced to 12x12.
// Holds the raster counters, frame FSM, valid strobe and end-of-frame pulse.
module pool_layer_1
  import pool_layer_1_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int IN_WIDTH  = L1_FMAP_SIZE,
  parameter int IN_HEIGHT = L1_FMAP_SIZE
) (
  input  logic                 clk_global,
  input  logic                 reset_layer,
  input  logic [DATA_BITS-1:0] in1,
  input  logic [DATA_BITS-1:0] in2,
  input  logic [DATA_BITS-1:0] in3,
  input  logic [DATA_BITS-1:0] in4,
  input  logic [DATA_BITS-1:0] in5,
  input  logic [DATA_BITS-1:0] in6,
  input  logic                 valid_in,
  output logic [DATA_BITS-1:0] out1,
  output logic [DATA_BITS-1:0] out2,
  output logic [DATA_BITS-1:0] out3,
  output logic [DATA_BITS-1:0] out4,
  output logic [DATA_BITS-1:0] out5,
  output logic [DATA_BITS-1:0] out6,
  output logic                 valid_out,
  output logic                 done
);

  localparam int COL_BITS = $clog2(IN_WIDTH);
  localparam int ROW_BITS = $clog2(IN_HEIGHT);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IN_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IN_HEIGHT - 1);

  logic [COL_BITS-1:0]  r_col;
  logic [ROW_BITS-1:0]  r_row;
  state_t               r_state;
  logic                 r_valid_out;
  logic                 r_done;

  logic                 w_col_last;
  logic                 w_row_last;
  logic [DATA_BITS-1:0] w_in  [L1_CHANNELS];
  logic [DATA_BITS-1:0] w_out [L1_CHANNELS];

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  assign w_in[0] = in1;
  assign w_in[1] = in2;
  assign w_in[2] = in3;
  assign w_in[3] = in4;
  assign w_in[4] = in5;
  assign w_in[5] = in6;

  // Raster position of the sample being presented; only valid samples advance it.
  always_ff @(posedge clk_global or negedge reset_layer) begin
    if (!reset_layer) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Frame FSM with registered strobes; S_DONE accepts the next frame's first sample directly.
  always_ff @(posedge clk_global or negedge reset_layer) begin
    if (!reset_layer) begin
      r_state     <= S_IDLE;
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_valid_out <= valid_in & r_row[0] & r_col[0];
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (valid_in && w_col_last && w_row_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= valid_in ? S_RUN : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < L1_CHANNELS; k++) begin : g_ch
    pool_channel #(
      .DATA_BITS (DATA_BITS),
      .IN_WIDTH  (IN_WIDTH),
      .COL_BITS  (COL_BITS)
    ) u_ch (
      .clk       (clk_global),
      .rst_n     (reset_layer),
      .i_valid   (valid_in),
      .i_col     (r_col),
      .i_row_odd (r_row[0]),
      .i_data    (w_in[k]),
      .o_data    (w_out[k])
    );
  end

  assign out1      = w_out[0];
  assign out2      = w_out[1];
  assign out3      = w_out[2];
  assign out4      = w_out[3];
  assign out5      = w_out[4];
  assign out6      = w_out[5];
  assign valid_out = r_valid_out;
  assign done      = r_done;

endmodule

// File: tb/tb_pool_layer_1.sv
// Directed bench for pool_layer_1: ramp, max sweep, gaps, saturation, mid-frame reset, back-to-back.
module tb_pool_layer_1;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int OW = W / 2;
  localparam int NOUT = (W / 2) * (H / 2);
  localparam logic [31:0] SAT  = 32'h0100_0000;
  localparam logic [31:0] HALF = 32'h0080_0000;

  logic        clk_global = 1'b0;
  logic        reset_layer = 1'b0;
  logic [31:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0, in5 = '0, in6 = '0;
  logic        valid_in = 1'b0;
  logic [31:0] out1, out2, out3, out4, out5, out6;
  logic        valid_out, done;

  int total = 0;
  int bad   = 0;

  logic [31:0] cap [0:319][0:5];
  logic [31:0] ref_ramp [0:NOUT-1][0:5];
  int cap_n    = 0;
  int done_cnt = 0;
  int done_at  = -1;

  pool_layer_1 dut (
    .clk_global (clk_global),
    .reset_layer(reset_layer),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6),
    .valid_in   (valid_in),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5), .out6(out6),
    .valid_out  (valid_out),
    .done       (done)
  );

  always #5 clk_global = ~clk_global;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_global) begin
    if (valid_out) begin
      if (cap_n < 320) begin
        cap[cap_n][0] = out1; cap[cap_n][1] = out2; cap[cap_n][2] = out3;
        cap[cap_n][3] = out4; cap[cap_n][4] = out5; cap[cap_n][5] = out6;
      end
      cap_n = cap_n + 1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      if (done_at < 0) done_at = cap_n;
    end
  end

  // mode 0: ramp (+base); mode 1: single 0x00800000 at window position base of output (3,5); mode 2: saturated
  function automatic logic [31:0] pix(input int mode, input int base, input int r, input int c, input int k);
    case (mode)
      0: pix = 32'(r * W + c + k + base);
      1: pix = (r == 6 + base / 2 && c == 10 + base % 2) ? HALF : 32'h0;
      default: pix = SAT;
    endcase
  endfunction

  task automatic clear_cap();
    cap_n = 0; done_cnt = 0; done_at = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_global);
      valid_in = 1'b0;
      in1 = $urandom; in2 = $urandom; in3 = $urandom;
      in4 = $urandom; in5 = $urandom; in6 = $urandom;
    end
  endtask

  // Presents nsamp samples in raster order; leaves the last one on the bus.
  task automatic drive_frame(input int mode, input int base, input int gap_pct, input int nsamp);
    int n;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < nsamp) begin
          while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
          @(negedge clk_global);
          valid_in = 1'b1;
          in1 = pix(mode, base, r, c, 0); in2 = pix(mode, base, r, c, 1);
          in3 = pix(mode, base, r, c, 2); in4 = pix(mode, base, r, c, 3);
          in5 = pix(mode, base, r, c, 4); in6 = pix(mode, base, r, c, 5);
          n++;
        end
      end
    end
  endtask

  task automatic check_frame_meta(input string name, input int exp_n, input int exp_done, input int exp_done_at);
    total++;
    if (cap_n !== exp_n) begin
      bad++; $display("FAIL %s strobes: got %0d expected %0d", name, cap_n, exp_n);
    end
    total++;
    if (done_cnt !== exp_done) begin
      bad++; $display("FAIL %s done count: got %0d expected %0d", name, done_cnt, exp_done);
    end
    total++;
    if (done_at !== exp_done_at) begin
      bad++; $display("FAIL %s done position: got %0d expected %0d", name, done_at, exp_done_at);
    end
  endtask

  task automatic check_ramp(input string name, input int base, input int first);
    logic [31:0] exp;
    for (int i = 0; i < NOUT; i++) begin
      for (int k = 0; k < 6; k++) begin
        exp = 32'(((2 * (i / OW) + 1) * W + 2 * (i % OW) + 1) + k + base);
        total++;
        if (cap[first + i][k] !== exp) begin
          bad++;
          $display("FAIL %s out[%0d] ch%0d: got %h expected %h", name, i, k, cap[first + i][k], exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_layer = 1'b0;
    repeat (3) @(negedge clk_global);
    total++;
    if ({out1, out2, out3, out4, out5, out6} !== 192'h0 || valid_out !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset outputs: got out1=%h valid=%b done=%b expected all zero", out1, valid_out, done);
    end
    reset_layer = 1'b1;
    idle(2);
  endtask

  task automatic test_ramp();
    clear_cap();
    drive_frame(0, 0, 0, W * H);
    idle(3);
    check_frame_meta("ramp", NOUT, 1, NOUT);
    check_ramp("ramp", 0, 0);
    total++;
    if (cap[0][0] !== 32'd25 || cap[NOUT-1][5] !== 32'd580) begin
      bad++; $display("FAIL ramp endpoints: got %0d/%0d expected 25/580", cap[0][0], cap[NOUT-1][5]);
    end
    for (int i = 0; i < NOUT; i++)
      for (int k = 0; k < 6; k++) ref_ramp[i][k] = cap[i][k];
  endtask

  task automatic test_max_sweep();
    logic [31:0] exp;
    for (int p = 0; p < 4; p++) begin
      clear_cap();
      drive_frame(1, p, 0, W * H);
      idle(3);
      check_frame_meta("sweep", NOUT, 1, NOUT);
      for (int i = 0; i < NOUT; i++) begin
        exp = (i == 3 * OW + 5) ? HALF : 32'h0;
        for (int k = 0; k < 6; k++) begin
          total++;
          if (cap[i][k] !== exp) begin
            bad++; $display("FAIL sweep pos%0d out[%0d] ch%0d: got %h expected %h", p, i, k, cap[i][k], exp);
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    clear_cap();
    drive_frame(0, 0, 40, W * H);
    idle(3);
    check_frame_meta("gaps", NOUT, 1, NOUT);
    check_ramp("gaps", 0, 0);
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (cap[i][3] !== ref_ramp[i][3]) begin
        bad++; $display("FAIL gaps vs continuous out[%0d]: got %h expected %h", i, cap[i][3], ref_ramp[i][3]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_cap();
    drive_frame(2, 0, 0, W * H);
    idle(3);
    check_frame_meta("sat", NOUT, 1, NOUT);
    for (int i = 0; i < NOUT; i++)
      for (int k = 0; k < 6; k++) begin
        total++;
        if (cap[i][k] !== SAT) begin
          bad++; $display("FAIL sat out[%0d] ch%0d: got %h expected %h", i, k, cap[i][k], SAT);
        end
      end
  endtask

  task automatic test_reset_midframe();
    clear_cap();
    drive_frame(0, 0, 0, 7 * W + 11);
    @(negedge clk_global);
    valid_in = 1'b0;
    total++;
    if (out1 === 32'h0) begin
      bad++; $display("FAIL midframe pre-reset out1: got %h expected nonzero", out1);
    end
    reset_layer = 1'b0;
    #1;
    total++;
    if ({out1, out2, out3, out4, out5, out6} !== 192'h0) begin
      bad++; $display("FAIL midframe reset outputs: got out1=%h out6=%h expected 0", out1, out6);
    end
    idle(3);
    total++;
    if ({out1, out2, out3, out4, out5, out6} !== 192'h0 || valid_out !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midframe held reset: got out1=%h valid=%b done=%b expected zero", out1, valid_out, done);
    end
    reset_layer = 1'b1;
    idle(2);
    clear_cap();
    drive_frame(0, 0, 0, W * H);
    idle(3);
    check_frame_meta("midframe", NOUT, 1, NOUT);
    check_ramp("midframe", 0, 0);
  endtask

  task automatic test_back_to_back();
    clear_cap();
    drive_frame(0, 0, 0, W * H);
    drive_frame(0, 1000, 0, W * H);
    idle(3);
    check_frame_meta("b2b", 2 * NOUT, 2, NOUT);
    check_ramp("b2b f1", 0, 0);
    check_ramp("b2b f2", 1000, NOUT);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (cap[NOUT][k] !== 32'(1025 + k)) begin
        bad++; $display("FAIL b2b f2 first ch%0d: got %0d expected %0d", k, cap[NOUT][k], 1025 + k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_max_sweep();
    test_gaps();
    test_saturation();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
